vargen_irq_ctrl: RTL



---
 rtl/vargen_irq_pkg.sv | 19 +
 rtl/vargen_irq_ctrl_if.sv | 29 ++
 rtl/vargen_irq_sync.sv | 32 +++
 rtl/vargen_irq_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/vargen_irq_pkg.sv
// vargen_irq_pkg: shared constants and types for the vargen interrupt controller.
//   - register offsets inside the 16-byte window
//   - default base address of the register block
//   - bus acknowledge FSM state type (also exported for debug)
package vargen_irq_pkg;

  localparam logic [3:0] OFS_PENDING  = 4'h0;
  localparam logic [3:0] OFS_ENABLE   = 4'h4;
  localparam logic [3:0] OFS_EDGE_SEL = 4'h8;
  localparam logic [3:0] OFS_RAW      = 4'hC;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0300_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_t;

endpackage

// File: rtl/vargen_irq_ctrl_if.sv
// vargen_irq_ctrl_if: native picoRV32 memory bus, one requester and one slave.
//   mem_valid / mem_addr / mem_wdata / mem_wstrb : request, driven by master
//   mem_ready / mem_rdata                        : response, driven by slave
//
// Handshake: the master raises mem_valid with a stable address, data and
// strobes and holds them until it sees mem_ready=1. A transfer completes on
// the clock edge at which mem_ready=1 is sampled by the master; mem_ready is
// a single-cycle pulse and mem_rdata is only meaningful while it is high.
// mem_wstrb=0 marks a read, any other value a write.
interface vargen_irq_ctrl_if;

  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/vargen_irq_sync.sv
// vargen_irq_sync: one interrupt line's synchroniser and edge detector.
//   clk, resetn : system clock, asynchronous active-low reset
//   pin         : raw asynchronous interrupt pin
//   level       : synchronised pin level (last synchroniser flop)
//   rise        : one-cycle rising event, level & ~previous level
module vargen_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic pin,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chain <= '0;
      hist  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      hist  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~hist;

endmodule

// File: rtl/vargen_irq_ctrl.sv
// vargen_irq_ctrl: interrupt controller in front of the picoRV32 core.
//   clk, resetn : system clock, asynchronous active-low reset
//   irq_in      : raw external interrupt pins (bit 0 = irq_5)
//   bus         : memory-mapped slave port (PENDING, ENABLE, EDGE_SEL, RAW)
//   cpu_irq     : registered interrupt vector, line i on bit IRQ_BASE+i
//   bus_state   : bus acknowledge FSM state, for debug/observation
module vargen_irq_ctrl
  import vargen_irq_pkg::*;
#(
  parameter int          NUM_IRQ     = 3,
  parameter int          IRQ_BASE    = 5,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_IRQ-1:0] irq_in,
  vargen_irq_ctrl_if.slave   bus,
  output logic [31:0]        cpu_irq,
  output bus_state_t         bus_state
);

  logic [NUM_IRQ-1:0] sync_level;
  logic [NUM_IRQ-1:0] sync_rise;
  logic [NUM_IRQ-1:0] pending, enable, edge_sel;
  logic [NUM_IRQ-1:0] pending_next, enable_next, edge_sel_next;
  logic [NUM_IRQ-1:0] wr_field, w1c;
  logic [31:0]        rdata_next, irq_next;
  logic [3:0]         ofs;
  logic               sel, wr_en;
  bus_state_t         state, state_next;

  // Write data above the register field and the upper byte strobes are
  // deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.mem_wdata[31:NUM_IRQ], bus.mem_wstrb[3:1]};

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    vargen_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .pin    (irq_in[i]),
      .level  (sync_level[i]),
      .rise   (sync_rise[i])
    );
  end

  // Bus FSM: IDLE accepts a request in the window, ACK is the single
  // mem_ready cycle. Leaving ACK unconditionally makes back-to-back requests
  // take two cycles each.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    sel        = 1'b0;
    case (state)
      ST_IDLE: begin
        sel = bus.mem_valid && (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
        if (sel) state_next = ST_ACK;
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.mem_ready = (state == ST_ACK);
  assign bus_state     = state;

  // Register decode. Read data is returned for any selected access; the
  // core ignores it on writes.
  always_comb begin
    ofs           = bus.mem_addr[3:0];
    wr_en         = sel && bus.mem_wstrb[0];
    wr_field      = bus.mem_wdata[NUM_IRQ-1:0];
    w1c           = '0;
    enable_next   = enable;
    edge_sel_next = edge_sel;
    rdata_next    = '0;
    case (ofs)
      OFS_PENDING: begin
        rdata_next[NUM_IRQ-1:0] = pending;
        if (wr_en) w1c = wr_field;
      end
      OFS_ENABLE: begin
        rdata_next[NUM_IRQ-1:0] = enable;
        if (wr_en) enable_next = wr_field;
      end
      OFS_EDGE_SEL: begin
        rdata_next[NUM_IRQ-1:0] = edge_sel;
        if (wr_en) edge_sel_next = wr_field;
      end
      OFS_RAW: rdata_next[NUM_IRQ-1:0] = sync_level;
      default: ;
    endcase

    // Edge lines: sticky, a new rising event beats a simultaneous clear.
    // Level lines: follow the synchronised pin, so clears do not stick.
    pending_next = (edge_sel & ((pending & ~w1c) | sync_rise))
                 | (~edge_sel & sync_level);

    // Uses the current ENABLE, so an ENABLE write shows one edge later.
    irq_next = '0;
    irq_next[IRQ_BASE +: NUM_IRQ] = pending_next & enable;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending       <= '0;
      enable        <= '0;
      edge_sel      <= '0;
      cpu_irq       <= '0;
      bus.mem_rdata <= '0;
    end else begin
      pending       <= pending_next;
      enable        <= enable_next;
      edge_sel      <= edge_sel_next;
      cpu_irq       <= irq_next;
      bus.mem_rdata <= sel ? rdata_next : '0;
    end
  end

endmodule
